// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared IDs and SRAM size encodings for the memory request arbiter
package mem_req_arbiter_pkg;

    // Order FIFO entry: which master owns an outstanding transaction
    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    // SRAM-like transfer size encodings
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - SRAM-like request/response port (req/addr_ok/data_ok) with master and slave views
interface mem_req_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // Issuer of requests (pipeline stage, or the arbiter toward the bridge)
    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Acceptor of requests (the arbiter toward a stage, or the bridge)
    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_req_arbiter_order_fifo.sv
// rtl/mem_req_arbiter_order_fifo.sv - arb_order_fifo: 1-bit-wide synchronous FIFO recording transaction issue order
module arb_order_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; push+pop together leaves count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage, pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one SRAM-like memory port between inst and data requesters; ARB_ROUND_ROBIN_EN selects round-robin grant
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.slave  inst,
    mem_req_arbiter_if.slave  data,
    mem_req_arbiter_if.master mem
);

    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic grant_id;
    logic grant_req;
    logic fifo_full;
    logic fifo_empty;
    logic head_id;
    logic accept;
    logic ret_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_q;

    // Remember who won the last accepted handshake so a contested grant alternates
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_q <= ARB_ID_INST;
        end else if (accept) begin
            last_winner_q <= grant_id;
        end
    end
`endif

    // Grant selection: a pending lock pins the grant so the payload cannot switch mid-handshake
    always_comb begin
        grant_id = ARB_ID_INST;
        if (lock_q) begin
            grant_id = lock_id_q;
`ifdef ARB_ROUND_ROBIN_EN
        end else if (data.req && inst.req) begin
            grant_id = ~last_winner_q;
`endif
        end else if (data.req) begin
            grant_id = ARB_ID_DATA;
        end
    end

    assign grant_req = (grant_id == ARB_ID_DATA) ? data.req : inst.req;
    assign mem.req   = !reset && grant_req && !fifo_full;
    assign accept    = mem.req && mem.addr_ok;

    // Lock follows an unaccepted request and drops on the accepting cycle
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (mem.req) begin
            lock_d    = 1'b1;
            lock_id_d = grant_id;
        end
    end

    // Lock state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= ARB_ID_INST;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Payload toward the bridge; held at zero when nothing is being issued
    always_comb begin
        mem.wr    = 1'b0;
        mem.size  = SIZE_B;
        mem.wstrb = '0;
        mem.addr  = '0;
        mem.wdata = '0;
        if (mem.req) begin
            if (grant_id == ARB_ID_DATA) begin
                mem.wr    = data.wr;
                mem.size  = data.size;
                mem.wstrb = data.wstrb;
                mem.addr  = data.addr;
                mem.wdata = data.wdata;
            end else begin
                mem.wr    = inst.wr;
                mem.size  = inst.size;
                mem.wstrb = inst.wstrb;
                mem.addr  = inst.addr;
                mem.wdata = inst.wdata;
            end
        end
    end

    assign data.addr_ok = accept && (grant_id == ARB_ID_DATA);
    assign inst.addr_ok = accept && (grant_id == ARB_ID_INST);

    arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_order_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (mem.data_ok),
        .din   (grant_id),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response with nothing outstanding is stray and goes nowhere
    assign ret_valid    = !reset && mem.data_ok && !fifo_empty;
    assign inst.data_ok = ret_valid && (head_id == ARB_ID_INST);
    assign data.data_ok = ret_valid && (head_id == ARB_ID_DATA);
    assign inst.rdata   = reset ? '0 : mem.rdata;
    assign data.rdata   = reset ? '0 : mem.rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_req_arbiter_if inst_bus ();
    mem_req_arbiter_if data_bus ();
    mem_req_arbiter_if mem_bus ();

    mem_req_arbiter #(
        .MAX_OUTSTANDING (2),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_bus),
        .data  (data_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'h0;
        inst_bus.addr = '0; inst_bus.wdata = '0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2; data_bus.wstrb = 4'h0;
        data_bus.addr = '0; data_bus.wdata = '0;
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = '0;

        // Reset: outputs quiet even with activity on the inputs
        step();
        inst_bus.req = 1'b1; mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
        settle();
        check_eq("rst_mem_req", mem_bus.req, 1'b0);
        check_eq("rst_inst_aok", inst_bus.addr_ok, 1'b0);
        check_eq("rst_inst_dok", inst_bus.data_ok, 1'b0);
        check_eq("rst_data_dok", data_bus.data_ok, 1'b0);
        step();
        reset = 1'b0; inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0;
        step();

        // Both request together: data first, inst next, returns in issue order
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1000_0000;
        data_bus.req = 1'b1; data_bus.addr = 32'h2000_0004; data_bus.wr = 1'b1;
        data_bus.wdata = 32'hCAFE_F00D; data_bus.wstrb = 4'hF;
        mem_bus.addr_ok = 1'b1;
        settle();
        check_eq("t1_mem_req", mem_bus.req, 1'b1);
        check_eq("t1_mem_addr", mem_bus.addr, 32'h2000_0004);
        check_eq("t1_mem_wr", mem_bus.wr, 1'b1);
        check_eq("t1_mem_wdata", mem_bus.wdata, 32'hCAFE_F00D);
        check_eq("t1_data_aok", data_bus.addr_ok, 1'b1);
        check_eq("t1_inst_aok", inst_bus.addr_ok, 1'b0);
        step();
        data_bus.req = 1'b0; data_bus.wr = 1'b0;
        settle();
        check_eq("t1_mem_addr2", mem_bus.addr, 32'h1000_0000);
        check_eq("t1_inst_aok2", inst_bus.addr_ok, 1'b1);
        check_eq("t1_data_aok2", data_bus.addr_ok, 1'b0);
        step();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h1111_1111;
        settle();
        check_eq("t1_ret1_data", data_bus.data_ok, 1'b1);
        check_eq("t1_ret1_inst", inst_bus.data_ok, 1'b0);
        check_eq("t1_ret1_rdata", data_bus.rdata, 32'h1111_1111);
        step();
        mem_bus.rdata = 32'h2222_2222;
        settle();
        check_eq("t1_ret2_inst", inst_bus.data_ok, 1'b1);
        check_eq("t1_ret2_data", data_bus.data_ok, 1'b0);
        check_eq("t1_ret2_rdata", inst_bus.rdata, 32'h2222_2222);
        step();
        mem_bus.data_ok = 1'b0;

        // Lock: inst waits for addr_ok, a later data request may not steal the grant
        inst_bus.req = 1'b1; inst_bus.addr = 32'h3000_0000;
        settle();
        check_eq("lk_mem_req", mem_bus.req, 1'b1);
        check_eq("lk_mem_addr0", mem_bus.addr, 32'h3000_0000);
        check_eq("lk_inst_aok0", inst_bus.addr_ok, 1'b0);
        step();
        settle();
        check_eq("lk_mem_addr1", mem_bus.addr, 32'h3000_0000);
        step();
        data_bus.req = 1'b1; data_bus.addr = 32'h4000_0000;
        settle();
        check_eq("lk_mem_addr2", mem_bus.addr, 32'h3000_0000);
        check_eq("lk_data_aok2", data_bus.addr_ok, 1'b0);
        step();
        mem_bus.addr_ok = 1'b1;
        settle();
        check_eq("lk_mem_addr3", mem_bus.addr, 32'h3000_0000);
        check_eq("lk_inst_aok3", inst_bus.addr_ok, 1'b1);
        check_eq("lk_data_aok3", data_bus.addr_ok, 1'b0);
        step();
        inst_bus.req = 1'b0;
        settle();
        check_eq("lk_mem_addr4", mem_bus.addr, 32'h4000_0000);
        check_eq("lk_data_aok4", data_bus.addr_ok, 1'b1);
        step();
        data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
        settle();
        check_eq("lk_ret_inst", inst_bus.data_ok, 1'b1);
        step();
        settle();
        check_eq("lk_ret_data", data_bus.data_ok, 1'b1);
        step();
        mem_bus.data_ok = 1'b0;

        // Full: two accepted, third blocked even with a same-cycle data_ok
        inst_bus.req = 1'b1; inst_bus.addr = 32'h5000_0000; mem_bus.addr_ok = 1'b1;
        settle();
        check_eq("fu_inst_aok0", inst_bus.addr_ok, 1'b1);
        step();
        settle();
        check_eq("fu_inst_aok1", inst_bus.addr_ok, 1'b1);
        step();
        settle();
        check_eq("fu_mem_req_full", mem_bus.req, 1'b0);
        check_eq("fu_inst_aok_full", inst_bus.addr_ok, 1'b0);
        mem_bus.data_ok = 1'b1;
        #1;
        check_eq("fu_mem_req_pop", mem_bus.req, 1'b0);
        check_eq("fu_inst_dok_pop", inst_bus.data_ok, 1'b1);
        step();
        mem_bus.data_ok = 1'b0;
        settle();
        check_eq("fu_mem_req_resume", mem_bus.req, 1'b1);
        check_eq("fu_inst_aok_resume", inst_bus.addr_ok, 1'b1);
        step();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
        settle();
        check_eq("fu_drain1", inst_bus.data_ok, 1'b1);
        step();
        settle();
        check_eq("fu_drain2", inst_bus.data_ok, 1'b1);
        step();

        // Stray data_ok while empty is ignored and does not underflow
        settle();
        check_eq("em_inst_dok", inst_bus.data_ok, 1'b0);
        check_eq("em_data_dok", data_bus.data_ok, 1'b0);
        step();
        mem_bus.data_ok = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h6000_0000; mem_bus.addr_ok = 1'b1;
        settle();
        check_eq("em_data_aok", data_bus.addr_ok, 1'b1);
        step();
        data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
        settle();
        check_eq("em_ret_data", data_bus.data_ok, 1'b1);
        check_eq("em_ret_inst", inst_bus.data_ok, 1'b0);
        step();
        settle();
        check_eq("em_stray_again", data_bus.data_ok, 1'b0);
        step();
        mem_bus.data_ok = 1'b0;

        // Reset with two outstanding clears the order FIFO
        inst_bus.req = 1'b1; inst_bus.addr = 32'h7000_0000; mem_bus.addr_ok = 1'b1;
        step();
        step();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
        reset = 1'b1; mem_bus.data_ok = 1'b1;
        settle();
        check_eq("rs_inst_dok", inst_bus.data_ok, 1'b0);
        check_eq("rs_mem_req", mem_bus.req, 1'b0);
        step();
        reset = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h8000_0000; mem_bus.addr_ok = 1'b1;
        settle();
        check_eq("rs_data_aok", data_bus.addr_ok, 1'b1);
        check_eq("rs_stray_inst", inst_bus.data_ok, 1'b0);
        check_eq("rs_stray_data", data_bus.data_ok, 1'b0);
        step();
        data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
        settle();
        check_eq("rs_ret_data", data_bus.data_ok, 1'b1);
        step();
        settle();
        check_eq("rs_ret_empty", data_bus.data_ok, 1'b0);
        step();
        mem_bus.data_ok = 1'b0;

        // Continuous contention with one return per cycle keeps the FIFO below full
        reset = 1'b1;
        step();
        reset = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h9000_0000;
        data_bus.req = 1'b1; data_bus.addr = 32'hA000_0000;
        mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
`ifdef ARB_ROUND_ROBIN_EN
            check_eq($sformatf("rr_data_aok%0d", i), data_bus.addr_ok, (i % 2 == 0) ? 1'b1 : 1'b0);
            check_eq($sformatf("rr_inst_aok%0d", i), inst_bus.addr_ok, (i % 2 == 0) ? 1'b0 : 1'b1);
`else
            check_eq($sformatf("fp_data_aok%0d", i), data_bus.addr_ok, 1'b1);
            check_eq($sformatf("fp_inst_aok%0d", i), inst_bus.addr_ok, 1'b0);
`endif
            step();
        end
        inst_bus.req = 1'b0; data_bus.req = 1'b0;
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
